// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA line fetcher: default geometry,
// tag bit positions and the fetch-state encoding.
package vga_pkg;

  localparam int XSIZE_DEF    = 320;
  localparam int YSIZE_DEF    = 240;
  localparam int TAG_UPD      = 10;
  localparam int TAG_LINE_MSB = 9;
  localparam int TAG_LINE_LSB = 0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/vga_linebank.sv
// One line of pixel storage: synchronous write port, synchronous read port.
// Contents are deliberately not reset.
module vga_linebank
  import vga_pkg::*;
#(
  parameter int DEPTH = XSIZE_DEF,
  parameter int AWB   = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [AWB-1:0] waddr_i,
  input  logic [15:0]    wdata_i,
  input  logic           re_i,
  input  logic [AWB-1:0] raddr_i,
  output logic [15:0]    rdata_o
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_linefetch.sv
// Double-buffered line fetcher: fills the write bank from frame memory while the timing side reads the other.
// Optional sticky overrun flag is built only when VGA_LINEFETCH_UNDERRUN_EN is defined.
module vga_linefetch
  import vga_pkg::*;
#(
  parameter int XSIZE = XSIZE_DEF,
  parameter int YSIZE = YSIZE_DEF,
  parameter int AW    = 17
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [10:0]   iTag,
  input  logic          iEn,
  output logic [15:0]   oData,
  output logic          oMemReq,
  output logic [AW-1:0] oMemAddr,
  input  logic          iMemAck,
  input  logic [15:0]   iMemData,
  output logic          oBusy,
  output logic          oUnderrun
);

  localparam int            PW   = $clog2(XSIZE);
  localparam logic [PW-1:0] LAST = PW'(XSIZE - 1);

  logic          upd;
  logic [9:0]    line;
  logic          line_ok;
  logic [AW-1:0] base;

  assign upd     = iTag[TAG_UPD];
  assign line    = iTag[TAG_LINE_MSB:TAG_LINE_LSB];
  assign line_ok = (32'(line) < 32'(YSIZE));
  assign base    = AW'(line) * AW'(XSIZE);

  fetch_state_e  state_q;
  logic [AW-1:0] addr_q;
  logic [PW-1:0] cnt_q;
  logic          req_q;
  logic          busy_q;

  // A strobe always wins over a same-cycle ack, so an aborted fetch never writes.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (upd) begin
      if (line_ok) begin
        state_q <= S_FETCH;
        addr_q  <= base;
        cnt_q   <= '0;
        req_q   <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
      end
    end else if (state_q == S_FETCH && iMemAck) begin
      addr_q <= addr_q + AW'(1);
      cnt_q  <= cnt_q + PW'(1);
      if (cnt_q == LAST) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
      end
    end
  end

  assign oMemReq  = req_q;
  assign oMemAddr = addr_q;
  assign oBusy    = busy_q;

`ifdef VGA_LINEFETCH_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                        underrun_q <= 1'b0;
    else if (upd && state_q == S_FETCH) underrun_q <= 1'b1;
  end

  assign oUnderrun = underrun_q;
`else
  assign oUnderrun = 1'b0;
`endif

  logic          rsel_q;
  logic          rd_sel_q;
  logic          en_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rptr_d;

  always_comb begin
    rptr_d = rptr_q;
    if (upd)       rptr_d = '0;
    else if (iEn)  rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rsel_q   <= 1'b0;
      rd_sel_q <= 1'b0;
      en_q     <= 1'b0;
      rptr_q   <= '0;
    end else begin
      en_q   <= iEn;
      rptr_q <= rptr_d;
      if (iEn) rd_sel_q <= rsel_q;
      if (upd) rsel_q <= ~rsel_q;
    end
  end

  // The write bank is always the complement of rsel, so the two ports never share a bank.
  logic        wr_en;
  logic [15:0] rd0;
  logic [15:0] rd1;

  assign wr_en = (state_q == S_FETCH) && iMemAck && !upd;

  vga_linebank #(.DEPTH(XSIZE), .AWB(PW)) u_bank0 (
    .clk_i   (CLOCK),
    .we_i    (wr_en && rsel_q),
    .waddr_i (cnt_q),
    .wdata_i (iMemData),
    .re_i    (iEn && !rsel_q),
    .raddr_i (rptr_q),
    .rdata_o (rd0)
  );

  vga_linebank #(.DEPTH(XSIZE), .AWB(PW)) u_bank1 (
    .clk_i   (CLOCK),
    .we_i    (wr_en && !rsel_q),
    .waddr_i (cnt_q),
    .wdata_i (iMemData),
    .re_i    (iEn && rsel_q),
    .raddr_i (rptr_q),
    .rdata_o (rd1)
  );

  assign oData = en_q ? (rd_sel_q ? rd1 : rd0) : 16'd0;

endmodule

// File: tb/tb_vga_linefetch.sv
// Directed bench for vga_linefetch: fetch, read-back, bank swap, abort, out-of-range line and reset.
module tb_vga_linefetch;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [10:0] iTag;
  logic        iEn;
  logic [15:0] oData;
  logic        oMemReq;
  logic [16:0] oMemAddr;
  logic        iMemAck;
  logic [15:0] iMemData;
  logic        oBusy;
  logic        oUnderrun;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef VGA_LINEFETCH_UNDERRUN_EN
  localparam logic [31:0] UR_EXP = 32'd1;
`else
  localparam logic [31:0] UR_EXP = 32'd0;
`endif

  vga_linefetch #(.XSIZE(320), .YSIZE(240), .AW(17)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .iTag      (iTag),
    .iEn       (iEn),
    .oData     (oData),
    .oMemReq   (oMemReq),
    .oMemAddr  (oMemAddr),
    .iMemAck   (iMemAck),
    .iMemData  (iMemData),
    .oBusy     (oBusy),
    .oUnderrun (oUnderrun)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int l);
    iTag = {1'b1, 10'(l)};
    tick;
    iTag = '0;
  endtask

  // Acks every cycle until the DUT drops its request; memory word = address.
  task automatic fetch_line(input int base, input string tag);
    int n = 0;
    while (oMemReq === 1'b1 && n < 400) begin
      chk({tag, "_addr"}, 32'(oMemAddr), base + n);
      iMemAck  = 1'b1;
      iMemData = oMemAddr[15:0];
      tick;
      n++;
    end
    iMemAck = 1'b0;
    chk({tag, "_acks"}, n, 320);
    chk({tag, "_busy_done"}, 32'(oBusy), 0);
  endtask

  initial begin
    int nack;
    int cyc;
    logic en_pat [6];
    int   exp_pat [6];

    RESET = 1'b1; iTag = '0; iEn = 1'b0; iMemAck = 1'b0; iMemData = '0;
    #12;
    chk("rst_data",  32'(oData), 0);
    chk("rst_req",   32'(oMemReq), 0);
    chk("rst_addr",  32'(oMemAddr), 0);
    chk("rst_busy",  32'(oBusy), 0);
    chk("rst_under", 32'(oUnderrun), 0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    tick;

    // Line 0 into bank 0 (rsel becomes 1).
    strobe(0);
    chk("l0_req",  32'(oMemReq), 1);
    chk("l0_busy", 32'(oBusy), 1);
    fetch_line(0, "l0");
    chk("l0_req_drop", 32'(oMemReq), 0);

    // Line 1 fetch while reading line 0 back.
    strobe(1);
    nack = 0;
    for (int i = 0; i < 320; i++) begin
      if (oMemReq === 1'b1) begin
        chk("l1_addr", 32'(oMemAddr), 320 + nack);
        iMemAck  = 1'b1;
        iMemData = oMemAddr[15:0];
        nack++;
      end else begin
        iMemAck = 1'b0;
      end
      iEn = 1'b1;
      tick;
      chk("rd_l0", 32'(oData), i);
    end
    iEn = 1'b0; iMemAck = 1'b0;
    chk("l1_acks", nack, 320);
    chk("l1_busy_done", 32'(oBusy), 0);
    tick;
    chk("rd_idle_zero", 32'(oData), 0);

    // Out-of-range line: swap only, bank 1 (line 1) becomes readable.
    strobe(240);
    for (int i = 0; i < 3; i++) begin
      chk("oor_req", 32'(oMemReq), 0);
      chk("oor_busy", 32'(oBusy), 0);
      tick;
    end
    en_pat  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_pat = '{320, 321, 322, 0, 0, 323};
    for (int i = 0; i < 6; i++) begin
      iEn = en_pat[i];
      tick;
      chk("en_pattern", 32'(oData), exp_pat[i]);
    end
    iEn = 1'b0;

    // Swap back: bank 0 must still hold line 0.
    strobe(240);
    chk("oor2_req", 32'(oMemReq), 0);
    for (int i = 0; i < 3; i++) begin
      iEn = 1'b1;
      tick;
      chk("wbank_kept", 32'(oData), i);
    end
    iEn = 1'b0;

    // Line 5 with sparse acks, then aborted by a second strobe coincident with an ack.
    strobe(5);
    chk("l5_start", 32'(oMemAddr), 1600);
    nack = 0; cyc = 0;
    while (nack < 200 && cyc < 1000) begin
      iMemAck = (cyc % 3 == 2);
      if (iMemAck) chk("l5_sparse_addr", 32'(oMemAddr), 1600 + nack);
      iMemData = oMemAddr[15:0];
      tick;
      if (iMemAck) nack++;
      cyc++;
    end
    iMemAck = 1'b0;
    tick;
    chk("pre_abort_addr", 32'(oMemAddr), 1800);
    chk("pre_abort_under", 32'(oUnderrun), 0);
    iTag = {1'b1, 10'd5}; iMemAck = 1'b1; iMemData = 16'hDEAD;
    tick;
    iTag = '0; iMemAck = 1'b0;
    chk("abort_addr",  32'(oMemAddr), 1600);
    chk("abort_req",   32'(oMemReq), 1);
    chk("abort_busy",  32'(oBusy), 1);
    chk("abort_under", 32'(oUnderrun), UR_EXP);
    fetch_line(1600, "l5");

    // Show the restarted line 5 through an out-of-range swap.
    strobe(300);
    chk("oor3_req", 32'(oMemReq), 0);
    for (int i = 0; i < 3; i++) begin
      iEn = 1'b1;
      tick;
      chk("rd_l5", 32'(oData), 1600 + i);
    end
    iEn = 1'b0;
    chk("under_sticky", 32'(oUnderrun), UR_EXP);

    // Reset in the middle of a fetch, while reading the partial aborted line.
    strobe(2);
    for (int i = 0; i < 100; i++) begin
      iMemAck  = 1'b1;
      iMemData = oMemAddr[15:0];
      iEn      = 1'b1;
      tick;
    end
    chk("mid_addr", 32'(oMemAddr), 740);
    chk("mid_data", 32'(oData), 1699);
    RESET = 1'b1;
    #1;
    chk("mrst_data",  32'(oData), 0);
    chk("mrst_req",   32'(oMemReq), 0);
    chk("mrst_addr",  32'(oMemAddr), 0);
    chk("mrst_busy",  32'(oBusy), 0);
    chk("mrst_under", 32'(oUnderrun), 0);
    tick;
    RESET = 1'b0; iEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_rst_req", 32'(oMemReq), 0);
    end
    iMemAck = 1'b0;
    strobe(0);
    chk("restart_req",  32'(oMemReq), 1);
    chk("restart_addr", 32'(oMemAddr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_linefetch.md
VGA_LINEFETCH -- requirements
Module: vga_linefetch

Interface
REQ-001 SHALL have parameter XSIZE, default 320: pixels per line.
REQ-002 SHALL have parameter YSIZE, default 240: lines per frame.
REQ-003 SHALL have parameter AW, default 17: frame-memory word address width.
REQ-004 SHALL have port CLOCK  in  1  system clock. All logic is on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port iTag  in  11  timing-side request. Bit [10] is a one-cycle update strobe; bits [9:0] are the line number to prepare.
REQ-007 SHALL have port iEn  in  1  timing-side pixel read enable.
REQ-008 SHALL have port oData  out  16  pixel to the timing side.
REQ-009 SHALL have port oMemReq  out  AW-independent 1  frame-memory word request.
REQ-010 SHALL have port oMemAddr  out  AW  frame-memory word address.
REQ-011 SHALL have port iMemAck  in  1  one-cycle acknowledge; iMemData is valid in the same cycle.
REQ-012 SHALL have port iMemData  in  16  frame-memory word.
REQ-013 SHALL have port oBusy  out  1  high while a line fetch is in progress.
REQ-014 SHALL have port oUnderrun  out  1  sticky fetch-overrun flag.

Function
REQ-015 SHALL hold two XSIZE x 16 line banks. One bank is the read bank (rsel); the other is the write bank.
REQ-016 On every update strobe (iTag[10]=1), SHALL toggle rsel and reset the read pointer to 0 in the same cycle.
REQ-017 Pixels delivered during a line period SHALL be the line fetched after the previous strobe.
REQ-018 Read side: when iEn=1, SHALL drive oData on the next cycle with rbank[rptr], then increment rptr. Read latency is 1 cycle.
REQ-019 When iEn=0, SHALL drive oData to 16'd0 on the next cycle and hold rptr.
REQ-020 rptr SHALL wrap from XSIZE-1 to 0.
REQ-021 Fetch FSM states SHALL be IDLE and FETCH.
REQ-022 IDLE: on a strobe with line L < YSIZE, SHALL load oMemAddr = L*XSIZE (AW-bit product) and cnt = 0, then go to FETCH.
REQ-023 IDLE: on a strobe with L >= YSIZE, SHALL still swap banks, start no fetch, and leave the write bank unmodified.
REQ-024 FETCH: oMemReq=1 and oBusy=1. On iMemAck, SHALL write iMemData to wbank[cnt], then increment cnt and oMemAddr.
REQ-025 FETCH: an ack with cnt = XSIZE-1 SHALL complete the line and return to IDLE. oMemReq SHALL drop on the following cycle.
REQ-026 When FETCH is not active, iMemAck SHALL be ignored.
REQ-027 A strobe while in FETCH SHALL abort the current fetch and set the overrun flag. It SHALL also swap banks and restart the fetch with the new L (or go to IDLE if L >= YSIZE).
REQ-028 An ack coincident with an aborting strobe SHALL be discarded.
REQ-029 Bank write and bank read SHALL never address the same bank in the same cycle. This holds by construction because wbank is always !rsel.

Reset
REQ-030 RESET high SHALL asynchronously force: oData=0, oMemReq=0, oMemAddr=0, oBusy=0, oUnderrun=0, FSM=IDLE, rsel=0, rptr=0, cnt=0.
REQ-031 Bank contents SHALL NOT be reset. Reads before the first complete fetch return undefined data.
REQ-032 RESET asserted mid-fetch SHALL abandon the fetch with no further memory requests.

Configuration
REQ-033 Macro VGA_LINEFETCH_UNDERRUN_EN: when defined, oUnderrun SHALL be set by REQ-027 and cleared only by RESET.
REQ-034 When VGA_LINEFETCH_UNDERRUN_EN is undefined, oUnderrun SHALL be constant 0 and the flag register SHALL be absent. Abort behaviour is unchanged.

Structure
REQ-035 Shared package vga_pkg SHALL hold: XSIZE/YSIZE defaults, the tag bit positions (TAG_UPD=10, TAG_LINE=9:0), and the fetch-state enum.
REQ-036 SHALL instantiate two copies of sub-module vga_linebank: XSIZE x 16, one synchronous write port, one synchronous read port.

Verification
REQ-037 Reset, then strobe L=0 with ack every cycle, memory word = address: SHALL issue addresses 0..319 and drop oBusy after 320 acks.
REQ-038 Second strobe L=1, then iEn high 320 cycles: oData SHALL return 0..319, 1 cycle after each iEn. Fetch addresses SHALL be 320..639.
REQ-039 Strobe L=5 with acks every 3rd cycle, second strobe after 200 acks: SHALL set oUnderrun=1 (with macro) and restart the fetch at address 1600 (with the second strobe carrying L=5).
REQ-040 Strobe L=240: SHALL swap banks with oMemReq staying 0 and the write-bank contents unchanged.
REQ-041 iEn pulsed 3 cycles, low 2, high 1: oData SHALL return pixels 0,1,2, then 0,0, then pixel 3.
REQ-042 RESET asserted at ack 100 of a fetch: all outputs SHALL read 0 within the reset cycle, with no oMemReq until the next strobe.
